// File: rtl/quad_encoder_gen_if.sv
// Command/observation bundle of the quadrature encoder emulator.
// master = commanding side, slave = the encoder generator.
interface quad_encoder_gen_if;
  logic        enable;
  logic [15:0] speed;
  logic [7:0]  direction;
  logic        outA;
  logic        outB;
  logic [31:0] position;
  logic        window_tick;
  logic [1:0]  quad_state;

  modport master (
    output enable, speed, direction,
    input  outA, outB, position, window_tick, quad_state
  );

  modport slave (
    input  enable, speed, direction,
    output outA, outB, position, window_tick, quad_state
  );
endinterface

// File: rtl/quad_encoder_gen.sv
// Quadrature encoder emulator: Bresenham step generator driving an A/B phase FSM,
// commanded once per measurement window in the encoder reader's speed/direction encoding.
module quad_encoder_gen #(
  parameter int WINDOW_CYCLES = 50000,
  parameter int ACC_W         = 32
) (
  input  logic          clk,
  input  logic          reset,
  quad_encoder_gen_if.slave bus
);

  localparam int                WCNT_W    = (WINDOW_CYCLES > 2) ? $clog2(WINDOW_CYCLES) : 1;
  localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(WINDOW_CYCLES - 1);
  localparam logic [ACC_W:0]    WIN_WIDE  = (ACC_W + 1)'(WINDOW_CYCLES);
  localparam logic [ACC_W-1:0]  WIN_ACC   = ACC_W'(WINDOW_CYCLES);
  localparam logic [31:0]       WIN_32    = 32'(WINDOW_CYCLES);

  typedef enum logic [1:0] {
    DIR_REV  = 2'd0,
    DIR_FWD  = 2'd1,
    DIR_STOP = 2'd2
  } dir_t;

  // State encoding is the {A,B} output pair itself.
  typedef enum logic [1:0] {
    Q00 = 2'b00,
    Q01 = 2'b01,
    Q11 = 2'b11,
    Q10 = 2'b10
  } quad_t;

  logic [WCNT_W-1:0] wcnt;
  logic [ACC_W-1:0]  acc;
  logic [ACC_W-1:0]  speed_q;
  dir_t              dir_q;
  logic [31:0]       position_q;
  quad_t             q_state;
  quad_t             q_next;

  logic              tick;
  logic [31:0]       speed_wide;
  logic [ACC_W-1:0]  speed_clamped;
  dir_t              dir_decoded;
  logic [ACC_W:0]    sum;
  logic              wrap_hit;
  logic              moving;
  logic              step;

  assign tick          = (wcnt == WCNT_LAST);
  assign speed_wide    = 32'(bus.speed);
  assign speed_clamped = (speed_wide > WIN_32) ? WIN_ACC : ACC_W'(speed_wide);
  assign sum           = {1'b0, acc} + {1'b0, speed_q};
  assign wrap_hit      = (sum >= WIN_WIDE);
  // The tick cycle is reserved for the command latch, so it never steps.
  assign moving        = !tick && bus.enable && (dir_q != DIR_STOP);
  assign step          = moving && wrap_hit;

  always_comb begin
    dir_decoded = DIR_STOP;
    case (bus.direction)
      8'd1:    dir_decoded = DIR_FWD;
      8'd0:    dir_decoded = DIR_REV;
      default: dir_decoded = DIR_STOP;
    endcase
  end

  // Window counter free-runs regardless of enable.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wcnt <= '0;
    end else if (tick) begin
      wcnt <= '0;
    end else begin
      wcnt <= wcnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      speed_q <= '0;
      dir_q   <= DIR_STOP;
    end else if (tick) begin
      speed_q <= speed_clamped;
      dir_q   <= dir_decoded;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc <= '0;
    end else if (tick) begin
      acc <= '0;
    end else if (moving) begin
      acc <= wrap_hit ? ACC_W'(sum - WIN_WIDE) : sum[ACC_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      position_q <= '0;
    end else if (step) begin
      position_q <= (dir_q == DIR_FWD) ? position_q + 32'd1 : position_q - 32'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q_state <= Q00;
    end else begin
      q_state <= q_next;
    end
  end

  // Forward walks 00-01-11-10 (B leads A); reverse walks the same ring backwards.
  always_comb begin
    q_next = q_state;
    if (step) begin
      if (dir_q == DIR_FWD) begin
        case (q_state)
          Q00:     q_next = Q01;
          Q01:     q_next = Q11;
          Q11:     q_next = Q10;
          Q10:     q_next = Q00;
          default: q_next = Q00;
        endcase
      end else begin
        case (q_state)
          Q00:     q_next = Q10;
          Q10:     q_next = Q11;
          Q11:     q_next = Q01;
          Q01:     q_next = Q00;
          default: q_next = Q00;
        endcase
      end
    end
  end

  always_comb begin
    bus.outA        = q_state[1];
    bus.outB        = q_state[0];
    bus.quad_state  = q_state;
    bus.position    = position_q;
    bus.window_tick = tick;
  end

endmodule

// File: tb/tb_quad_encoder_gen.sv
// Directed-plus-random bench for quad_encoder_gen with a per-cycle reference model
// that counts steps arithmetically from the enabled-cycle index within each window.
module tb_quad_encoder_gen;

  localparam int W = 100;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  quad_encoder_gen_if bus ();

  quad_encoder_gen #(
    .WINDOW_CYCLES(W),
    .ACC_W        (32)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model state
  int          m_wcnt;
  int          m_k;
  int          m_sq;
  int          m_idx;
  logic [7:0]  m_dir;
  logic [31:0] m_pos;
  logic [1:0]  seq [4] = '{2'b00, 2'b01, 2'b11, 2'b10};

  function automatic int steps_full(input int s);
    int c;
    c = (s > W) ? W : s;
    return ((W - 1) * c) / W;
  endfunction

  task automatic model_reset();
    m_wcnt = 0;
    m_k    = 0;
    m_sq   = 0;
    m_idx  = 0;
    m_dir  = 8'hFF;
    m_pos  = '0;
  endtask

  // One clock edge: a step happens on the k-th enabled cycle of a window
  // whenever floor(k*speed/W) advances.
  task automatic model_edge();
    if (m_wcnt == W - 1) begin
      m_wcnt = 0;
      m_sq   = (int'(bus.speed) > W) ? W : int'(bus.speed);
      m_dir  = bus.direction;
      m_k    = 0;
    end else begin
      m_wcnt++;
      if (bus.enable && (m_dir == 8'd0 || m_dir == 8'd1)) begin
        m_k++;
        if ((m_k * m_sq) / W != ((m_k - 1) * m_sq) / W) begin
          if (m_dir == 8'd1) begin
            m_idx = (m_idx + 1) % 4;
            m_pos = m_pos + 32'd1;
          end else begin
            m_idx = (m_idx + 3) % 4;
            m_pos = m_pos - 32'd1;
          end
        end
      end
    end
  endtask

  task automatic check_outputs(input string tag);
    logic [34:0] got;
    logic [34:0] exp;
    got = {bus.outA, bus.outB, bus.position, bus.window_tick};
    exp = {seq[m_idx], m_pos, (m_wcnt == W - 1)};
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s: got A=%0b B=%0b pos=%0d tick=%0b, expected A=%0b B=%0b pos=%0d tick=%0b",
             tag, got[34], got[33], $signed(got[32:1]), got[0],
             exp[34], exp[33], $signed(exp[32:1]), exp[0]);
    end
  endtask

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s: got %0d, expected %0d", tag, $signed(got), $signed(exp));
    end
  endtask

  // Caller is at a negedge; advances n edges and checks after each.
  task automatic run_cycles(input int n, input string tag, input bit rnd_en);
    logic pa, pb;
    for (int i = 0; i < n; i++) begin
      if (rnd_en) bus.enable = ($urandom_range(0, 3) != 0);
      pa = bus.outA;
      pb = bus.outB;
      model_edge();
      @(posedge clk);
      @(negedge clk);
      check_outputs(tag);
      if (pa !== bus.outA && pb !== bus.outB) begin
        checks++;
        failures++;
        $error("FAIL %s_one_toggle: got both A and B toggled, expected one", tag);
      end
      if (pa === 1'b0 && bus.outA === 1'b1) begin
        checks++;
        assert (bus.outB === (m_dir == 8'd1)) else begin
          failures++;
          $error("FAIL %s_b_at_a_rise: got B=%0b, expected %0b", tag, bus.outB, (m_dir == 8'd1));
        end
      end
    end
  endtask

  logic [31:0] p0;
  bit          found;

  initial begin
    // Reset with forward speed 10 already applied
    reset         = 1'b0;
    bus.enable    = 1'b1;
    bus.speed     = 16'd10;
    bus.direction = 8'd1;
    model_reset();
    repeat (3) @(negedge clk);
    reset = 1'b1;
    check_outputs("reset_state");

    // Window 1 idle, window 2 forward at 10
    run_cycles(W, "win1", 1'b0);
    check_val("win1_no_steps", bus.position, 32'd0);
    run_cycles(W, "win2_fwd10", 1'b0);
    check_val("win2_pos", bus.position, 32'(steps_full(10)));

    // Reverse at 7: latched at next tick
    bus.speed     = 16'd7;
    bus.direction = 8'd0;
    run_cycles(W, "rev7_latency", 1'b0);
    p0 = bus.position;
    run_cycles(W, "rev7", 1'b0);
    check_val("rev7_delta", bus.position, p0 - 32'(steps_full(7)));

    // Speed above window length clamps to one step per non-tick cycle
    bus.speed     = 16'd250;
    bus.direction = 8'd1;
    run_cycles(W, "clamp_latency", 1'b0);
    p0 = bus.position;
    run_cycles(W, "clamp", 1'b0);
    check_val("clamp_delta", bus.position, p0 + 32'd99);

    // Mid-window command change is ignored until the next tick
    bus.speed     = 16'd10;
    bus.direction = 8'd1;
    run_cycles(W, "mid_setup", 1'b0);
    p0 = bus.position;
    run_cycles(50, "mid_first_half", 1'b0);
    bus.speed     = 16'd40;
    bus.direction = 8'd5;
    run_cycles(50, "mid_second_half", 1'b0);
    check_val("mid_window_kept", bus.position, p0 + 32'(steps_full(10)));
    p0 = bus.position;
    run_cycles(W, "stop_window", 1'b0);
    check_val("stop_holds", bus.position, p0);

    // Random commands with random enable gaps
    for (int w = 0; w < 8; w++) begin
      bus.speed = 16'($urandom_range(0, 300));
      case ($urandom_range(0, 3))
        0:       bus.direction = 8'd0;
        1:       bus.direction = 8'd1;
        2:       bus.direction = 8'($urandom_range(2, 255));
        default: bus.direction = 8'd1;
      endcase
      run_cycles(W, "random", 1'b1);
    end

    // Asynchronous reset while outputs are 11
    bus.enable    = 1'b1;
    bus.speed     = 16'd100;
    bus.direction = 8'd1;
    found         = 1'b0;
    for (int i = 0; i < 3 * W && !found; i++) begin
      run_cycles(1, "seek_11", 1'b0);
      if (m_wcnt > 0 && m_wcnt < W - 2 && bus.outA === 1'b1 && bus.outB === 1'b1) found = 1'b1;
    end
    checks++;
    if (!found) begin
      failures++;
      $error("FAIL seek_11_timeout: got no 11 state within %0d cycles, expected one", 3 * W);
    end
    #2 reset = 1'b0;
    #1;
    check_val("async_rst_outA", 32'(bus.outA), 32'd0);
    check_val("async_rst_outB", 32'(bus.outB), 32'd0);
    check_val("async_rst_pos", bus.position, 32'd0);
    check_val("async_rst_tick", 32'(bus.window_tick), 32'd0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    check_outputs("after_async_reset");
    run_cycles(2 * W, "post_reset", 1'b0);
    check_val("post_reset_pos", bus.position, 32'd99);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
